// File: rtl/projectile_pool_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : projectile_pool_if
// Purpose  : Launch request channel (game -> pool) and crater request channel
//            (pool -> terrain deformer), both valid/ready.
// Signals  : launch_valid/launch_ready, launch_x/y, launch_vx/vy (signed),
//            crater_valid/crater_ready, crater_x/y, crater_r.
// Modports : master - game/deformer side, slave - projectile_pool side.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
interface projectile_pool_if #(
   parameter int COORD_W = 10,
   parameter int VEL_W   = 10
);
   logic                    launch_valid;
   logic                    launch_ready;
   logic [COORD_W-1:0]      launch_x;
   logic [COORD_W-1:0]      launch_y;
   logic signed [VEL_W-1:0] launch_vx;
   logic signed [VEL_W-1:0] launch_vy;
   logic                    crater_valid;
   logic                    crater_ready;
   logic [COORD_W-1:0]      crater_x;
   logic [COORD_W-1:0]      crater_y;
   logic [COORD_W-1:0]      crater_r;

   modport master (
      output launch_valid, launch_x, launch_y, launch_vx, launch_vy, crater_ready,
      input  launch_ready, crater_valid, crater_x, crater_y, crater_r
   );

   modport slave (
      input  launch_valid, launch_x, launch_y, launch_vx, launch_vy, crater_ready,
      output launch_ready, crater_valid, crater_x, crater_y, crater_r
   );
endinterface
`default_nettype wire

// File: rtl/projectile_pool.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : projectile_pool
// Purpose  : N_SLOTS independent shells: launch, per-frame ballistics (gravity,
//            wind, velocity clamp), terrain/screen-exit detection, crater
//            requests and a timed explosion phase; per-pixel sprite hit lookup.
// Ports    : clk, reset (async, active-high)
//            bus          - launch and crater valid/ready channels (slave)
//            i_frame_tick - one-cycle pulse per video frame
//            i_wind       - signed wind step (-2 treated as 0)
//            i_hit        - per-slot terrain collision, sampled on frame tick
//            o_slot_x/y   - packed slot centre positions
//            o_active     - slot is in flight
//            i_draw_x/y   - current pixel; o_draw_hit/slot/addr - sprite hit
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module projectile_pool #(
   parameter int N_SLOTS     = 4,
   parameter int COORD_W     = 10,
   parameter int VEL_W       = 10,
   parameter int V_MAX       = 12,
   parameter int GRAV_DIV    = 6,
   parameter int WIND_DIV    = 8,
   parameter int X_MIN       = 5,
   parameter int X_MAX       = 634,
   parameter int Y_MIN       = 5,
   parameter int Y_MAX       = 474,
   parameter int BOOM_FRAMES = 16,
   parameter int BOOM_RADIUS = 20,
   parameter int SPR_W       = 12,
   parameter int SPR_H       = 17,
   parameter int SPR_CX      = 5,
   parameter int SPR_CY      = 9
) (
   input  wire logic                   clk,
   input  wire logic                   reset,
   projectile_pool_if.slave            bus,
   input  wire logic                   i_frame_tick,
   input  wire logic [1:0]             i_wind,
   input  wire logic [N_SLOTS-1:0]     i_hit,
   output logic [N_SLOTS*COORD_W-1:0]  o_slot_x,
   output logic [N_SLOTS*COORD_W-1:0]  o_slot_y,
   output logic [N_SLOTS-1:0]          o_active,
   input  wire logic [COORD_W-1:0]     i_draw_x,
   input  wire logic [COORD_W-1:0]     i_draw_y,
   output logic                        o_draw_hit,
   output logic [2:0]                  o_draw_slot,
   output logic [10:0]                 o_draw_addr
);
   localparam int PW = COORD_W + 2;   // signed position width, no wrap
   localparam int GW = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;
   localparam int WW = (WIND_DIV > 1) ? $clog2(WIND_DIV) : 1;
   localparam int BW = $clog2(BOOM_FRAMES + 1);

   localparam logic [GW-1:0] c_G_LAST = GW'(GRAV_DIV - 1);
   localparam logic [WW-1:0] c_W_LAST = WW'(WIND_DIV - 1);
   localparam logic [BW-1:0] c_B_END  = BW'(BOOM_FRAMES);
   localparam logic signed [VEL_W:0] c_V_HI = (VEL_W+1)'(V_MAX);
   localparam logic signed [VEL_W:0] c_V_LO = -c_V_HI;
   localparam logic signed [PW-1:0] c_X_MIN  = PW'(X_MIN);
   localparam logic signed [PW-1:0] c_X_MAX  = PW'(X_MAX);
   localparam logic signed [PW-1:0] c_Y_MIN  = PW'(Y_MIN);
   localparam logic signed [PW-1:0] c_Y_MAX  = PW'(Y_MAX);
   localparam logic signed [PW-1:0] c_SPR_W  = PW'(SPR_W);
   localparam logic signed [PW-1:0] c_SPR_H  = PW'(SPR_H);
   localparam logic signed [PW-1:0] c_SPR_CX = PW'(SPR_CX);
   localparam logic signed [PW-1:0] c_SPR_CY = PW'(SPR_CY);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FLIGHT = 2'd1,
      S_BOOM   = 2'd2
   } slot_state_t;

   slot_state_t             r_state [N_SLOTS], w_state_nx [N_SLOTS];
   logic [COORD_W-1:0]      r_x [N_SLOTS], w_x_nx [N_SLOTS];
   logic [COORD_W-1:0]      r_y [N_SLOTS], w_y_nx [N_SLOTS];
   logic signed [VEL_W-1:0] r_vx [N_SLOTS], w_vx_nx [N_SLOTS];
   logic signed [VEL_W-1:0] r_vy [N_SLOTS], w_vy_nx [N_SLOTS];
   logic [GW-1:0]           r_g [N_SLOTS], w_g_nx [N_SLOTS];
   logic [WW-1:0]           r_w [N_SLOTS], w_w_nx [N_SLOTS];
   logic [BW-1:0]           r_b [N_SLOTS], w_b_nx [N_SLOTS];
   logic                    r_pend [N_SLOTS], w_pend_nx [N_SLOTS];
   logic                    r_lock;      // crater output frozen on r_lock_idx
   logic [2:0]              r_lock_idx;

   logic [N_SLOTS-1:0]      w_lsel;
   logic                    w_lfound, w_do_launch;
   logic                    w_pend_any, w_ack;
   logic [2:0]              w_csel;
   logic [COORD_W-1:0]      w_crater_x, w_crater_y;
   logic signed [VEL_W:0]   w_wind_w, w_vxw, w_vyw;
   logic signed [PW-1:0]    w_px, w_py, w_dx, w_dy, w_addr;

   function automatic logic signed [VEL_W-1:0] f_clamp(input logic signed [VEL_W:0] v);
      logic signed [VEL_W:0] t;
      t = v;
      if (v > c_V_HI)      t = c_V_HI;
      else if (v < c_V_LO) t = c_V_LO;
      return t[VEL_W-1:0];
   endfunction

   function automatic logic signed [PW-1:0] f_sext(input logic signed [VEL_W-1:0] v);
      return $signed({{(PW-VEL_W){v[VEL_W-1]}}, v});
   endfunction

   // Launch target: lowest-index IDLE slot from registered state
   always_comb begin
      w_lsel   = '0;
      w_lfound = 1'b0;
      for (int i = 0; i < N_SLOTS; i++) begin
         if (!w_lfound && r_state[i] == S_IDLE) begin
            w_lsel[i] = 1'b1;
            w_lfound  = 1'b1;
         end
      end
   end

   assign bus.launch_ready = w_lfound;
   assign w_do_launch      = bus.launch_valid && w_lfound;

   // Crater arbiter: lowest pending slot, held once presented until accepted
   always_comb begin
      w_pend_any = 1'b0;
      w_csel     = '0;
      for (int i = N_SLOTS - 1; i >= 0; i--) begin
         if (r_pend[i]) begin
            w_pend_any = 1'b1;
            w_csel     = 3'(i);
         end
      end
      if (r_lock) w_csel = r_lock_idx;
      w_crater_x = '0;
      w_crater_y = '0;
      for (int i = 0; i < N_SLOTS; i++) begin
         if (w_pend_any && 3'(i) == w_csel) begin
            w_crater_x = r_x[i];
            w_crater_y = r_y[i];
         end
      end
   end

   assign w_ack            = w_pend_any && bus.crater_ready;
   assign bus.crater_valid = w_pend_any;
   assign bus.crater_x     = w_crater_x;
   assign bus.crater_y     = w_crater_y;
   assign bus.crater_r     = COORD_W'(BOOM_RADIUS);

   // -2 on the wind input is an unused code and counts as calm
   assign w_wind_w = (i_wind == 2'b10) ? '0 : $signed({{(VEL_W-1){i_wind[1]}}, i_wind});

   // Slot next-state
   always_comb begin
      w_px = '0;
      w_py = '0;
      w_vxw = '0;
      w_vyw = '0;
      for (int i = 0; i < N_SLOTS; i++) begin
         w_state_nx[i] = r_state[i];
         w_x_nx[i]     = r_x[i];
         w_y_nx[i]     = r_y[i];
         w_vx_nx[i]    = r_vx[i];
         w_vy_nx[i]    = r_vy[i];
         w_g_nx[i]     = r_g[i];
         w_w_nx[i]     = r_w[i];
         w_b_nx[i]     = r_b[i];
         w_pend_nx[i]  = r_pend[i];
         w_px  = '0;
         w_py  = '0;
         w_vxw = '0;
         w_vyw = '0;
         if (w_ack && 3'(i) == w_csel) w_pend_nx[i] = 1'b0;
         case (r_state[i])
            S_IDLE: begin
               if (w_do_launch && w_lsel[i]) begin
                  w_state_nx[i] = S_FLIGHT;
                  w_x_nx[i]     = bus.launch_x;
                  w_y_nx[i]     = bus.launch_y;
                  w_vx_nx[i]    = bus.launch_vx;
                  w_vy_nx[i]    = bus.launch_vy;
                  w_g_nx[i]     = '0;
                  w_w_nx[i]     = '0;
               end
            end
            S_FLIGHT: begin
               if (i_frame_tick) begin
                  w_px = $signed({2'b00, r_x[i]}) + f_sext(r_vx[i]);
                  w_py = $signed({2'b00, r_y[i]}) + f_sext(r_vy[i]);
                  // Terrain hit or screen exit: explode where the shell was
                  if (i_hit[i] || w_px < c_X_MIN || w_px > c_X_MAX ||
                      w_py < c_Y_MIN || w_py > c_Y_MAX) begin
                     w_state_nx[i] = S_BOOM;
                     w_pend_nx[i]  = 1'b1;
                     w_b_nx[i]     = '0;
                  end else begin
                     w_x_nx[i] = w_px[COORD_W-1:0];
                     w_y_nx[i] = w_py[COORD_W-1:0];
                     w_vxw = {r_vx[i][VEL_W-1], r_vx[i]};
                     w_vyw = {r_vy[i][VEL_W-1], r_vy[i]};
                     if (r_g[i] == c_G_LAST) begin
                        w_g_nx[i] = '0;
                        w_vyw     = w_vyw + (VEL_W+1)'(1);
                     end else begin
                        w_g_nx[i] = r_g[i] + GW'(1);
                     end
                     if (r_w[i] == c_W_LAST) begin
                        w_w_nx[i] = '0;
                        w_vxw     = w_vxw + w_wind_w;
                     end else begin
                        w_w_nx[i] = r_w[i] + WW'(1);
                     end
                     w_vx_nx[i] = f_clamp(w_vxw);
                     w_vy_nx[i] = f_clamp(w_vyw);
                  end
               end
            end
            S_BOOM: begin
               if (i_frame_tick) begin
                  w_b_nx[i] = (r_b[i] == c_B_END) ? r_b[i] : r_b[i] + BW'(1);
                  // Crater must have been accepted before this edge
                  if (w_b_nx[i] == c_B_END && !r_pend[i]) w_state_nx[i] = S_IDLE;
               end
            end
            default: w_state_nx[i] = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_SLOTS; i++) begin
            r_state[i] <= S_IDLE;
            r_x[i]     <= '0;
            r_y[i]     <= '0;
            r_vx[i]    <= '0;
            r_vy[i]    <= '0;
            r_g[i]     <= '0;
            r_w[i]     <= '0;
            r_b[i]     <= '0;
            r_pend[i]  <= 1'b0;
         end
         r_lock     <= 1'b0;
         r_lock_idx <= '0;
      end else begin
         for (int i = 0; i < N_SLOTS; i++) begin
            r_state[i] <= w_state_nx[i];
            r_x[i]     <= w_x_nx[i];
            r_y[i]     <= w_y_nx[i];
            r_vx[i]    <= w_vx_nx[i];
            r_vy[i]    <= w_vy_nx[i];
            r_g[i]     <= w_g_nx[i];
            r_w[i]     <= w_w_nx[i];
            r_b[i]     <= w_b_nx[i];
            r_pend[i]  <= w_pend_nx[i];
         end
         r_lock     <= w_pend_any && !bus.crater_ready;
         r_lock_idx <= w_csel;
      end
   end

   // Collider feed and status
   always_comb begin
      for (int i = 0; i < N_SLOTS; i++) begin
         o_slot_x[i*COORD_W +: COORD_W] = r_x[i];
         o_slot_y[i*COORD_W +: COORD_W] = r_y[i];
         o_active[i] = (r_state[i] == S_FLIGHT);
      end
   end

   // Sprite hit: scan high to low so the lowest matching slot wins
   always_comb begin
      o_draw_hit  = 1'b0;
      o_draw_slot = '0;
      o_draw_addr = '0;
      w_dx = '0;
      w_dy = '0;
      w_addr = '0;
      for (int i = N_SLOTS - 1; i >= 0; i--) begin
         w_dx = $signed({2'b00, i_draw_x}) - $signed({2'b00, r_x[i]}) + c_SPR_CX;
         w_dy = $signed({2'b00, i_draw_y}) - $signed({2'b00, r_y[i]}) + c_SPR_CY;
         w_addr = w_dy * c_SPR_W + w_dx;
         if (r_state[i] == S_FLIGHT && w_dx >= 0 && w_dx < c_SPR_W &&
             w_dy >= 0 && w_dy < c_SPR_H) begin
            o_draw_hit  = 1'b1;
            o_draw_slot = 3'(i);
            o_draw_addr = 11'(w_addr);
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_projectile_pool.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_projectile_pool
// Purpose  : Directed and randomized checks of projectile_pool against an
//            integer reference model of the slot rules.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_projectile_pool;
   localparam int N = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        frame_tick;
   logic [1:0]  wind;
   logic [N-1:0] hit;
   logic [N*10-1:0] slot_x, slot_y;
   logic [N-1:0] active;
   logic [9:0]  draw_x, draw_y;
   logic        draw_hit;
   logic [2:0]  draw_slot;
   logic [10:0] draw_addr;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: 0 idle, 1 flight, 2 boom
   int m_st[N], m_x[N], m_y[N], m_vx[N], m_vy[N], m_g[N], m_w[N], m_b[N];
   bit m_pend[N];
   int m_serv;

   always #5 clk = ~clk;

   projectile_pool_if #(.COORD_W(10), .VEL_W(10)) bus ();

   projectile_pool dut (
      .clk(clk), .reset(reset), .bus(bus),
      .i_frame_tick(frame_tick), .i_wind(wind), .i_hit(hit),
      .o_slot_x(slot_x), .o_slot_y(slot_y), .o_active(active),
      .i_draw_x(draw_x), .i_draw_y(draw_y),
      .o_draw_hit(draw_hit), .o_draw_slot(draw_slot), .o_draw_addr(draw_addr)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_st[i] = 0; m_x[i] = 0; m_y[i] = 0; m_vx[i] = 0; m_vy[i] = 0;
         m_g[i] = 0; m_w[i] = 0; m_b[i] = 0; m_pend[i] = 0;
      end
      m_serv = -1;
   endtask

   function automatic int first_idle();
      for (int i = 0; i < N; i++) if (m_st[i] == 0) return i;
      return -1;
   endfunction

   function automatic int crater_sel();
      if (m_serv >= 0) return m_serv;
      for (int i = 0; i < N; i++) if (m_pend[i]) return i;
      return -1;
   endfunction

   function automatic int clampv(input int v);
      return (v > 12) ? 12 : ((v < -12) ? -12 : v);
   endfunction

   // Advance the model across one clock edge using the current inputs
   task automatic model_edge();
      int li, cs, we, nx, ny;
      bit ack;
      li  = first_idle();
      cs  = crater_sel();
      ack = (cs >= 0) && bus.crater_ready;
      we  = (wind == 2'b01) ? 1 : ((wind == 2'b11) ? -1 : 0);
      for (int i = 0; i < N; i++) begin
         if (frame_tick && m_st[i] == 1) begin
            nx = m_x[i] + m_vx[i];
            ny = m_y[i] + m_vy[i];
            if (hit[i] || nx < 5 || nx > 634 || ny < 5 || ny > 474) begin
               m_st[i] = 2; m_pend[i] = 1; m_b[i] = 0;
            end else begin
               m_x[i] = nx; m_y[i] = ny;
               if (m_g[i] == 5) begin m_g[i] = 0; m_vy[i] += 1; end else m_g[i] += 1;
               if (m_w[i] == 7) begin m_w[i] = 0; m_vx[i] += we; end else m_w[i] += 1;
               m_vx[i] = clampv(m_vx[i]);
               m_vy[i] = clampv(m_vy[i]);
            end
         end else if (frame_tick && m_st[i] == 2) begin
            if (m_b[i] < 16) m_b[i] += 1;
            if (m_b[i] == 16 && !m_pend[i]) m_st[i] = 0;
         end
      end
      if (ack) m_pend[cs] = 0;
      if (bus.launch_valid && li >= 0) begin
         m_st[li] = 1;
         m_x[li] = int'(bus.launch_x);  m_y[li] = int'(bus.launch_y);
         m_vx[li] = int'(bus.launch_vx); m_vy[li] = int'(bus.launch_vy);
         m_g[li] = 0; m_w[li] = 0;
      end
      m_serv = (cs >= 0 && !ack) ? cs : -1;
   endtask

   task automatic check_all();
      logic [N*10-1:0] ex, ey;
      logic [N-1:0] act;
      int cs, dh, ds, da, l, t, px, py;
      bit found;
      for (int i = 0; i < N; i++) begin
         ex[i*10 +: 10] = 10'(m_x[i]);
         ey[i*10 +: 10] = 10'(m_y[i]);
         act[i] = (m_st[i] == 1);
      end
      cs = crater_sel();
      chk("launch_ready", bus.launch_ready, 64'(first_idle() >= 0));
      chk("active", active, act);
      chk("crater_valid", bus.crater_valid, 64'(cs >= 0));
      chk("crater_x", bus.crater_x, (cs >= 0) ? 64'(m_x[cs]) : 64'd0);
      chk("crater_y", bus.crater_y, (cs >= 0) ? 64'(m_y[cs]) : 64'd0);
      chk("crater_r", bus.crater_r, 64'd20);
      chk("slot_x", slot_x, ex);
      chk("slot_y", slot_y, ey);
      dh = 0; ds = 0; da = 0; found = 0;
      px = int'(draw_x); py = int'(draw_y);
      for (int i = 0; i < N; i++) begin
         l = m_x[i] - 5; t = m_y[i] - 9;
         if (!found && m_st[i] == 1 && px >= l && px <= l + 11 && py >= t && py <= t + 16) begin
            found = 1; dh = 1; ds = i; da = 12 * (py - t) + (px - l);
         end
      end
      chk("draw_hit", draw_hit, 64'(dh));
      chk("draw_slot", draw_slot, 64'(ds));
      chk("draw_addr", draw_addr, 64'(da));
   endtask

   task automatic cyc();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic tick();
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      cyc();
   endtask

   task automatic set_launch(input int x, input int y, input int vx, input int vy);
      bus.launch_x  = 10'(x);
      bus.launch_y  = 10'(y);
      bus.launch_vx = 10'(vx);
      bus.launch_vy = 10'(vy);
   endtask

   task automatic clear_inputs();
      bus.launch_valid = 1'b0; bus.crater_ready = 1'b0;
      set_launch(0, 0, 0, 0);
      frame_tick = 1'b0; wind = 2'b00; hit = '0; draw_x = '0; draw_y = '0;
   endtask

   // Reset is asynchronous: outputs must drop before any clock edge
   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      #1;
      chk("rst_crater_valid", bus.crater_valid, 64'd0);
      chk("rst_launch_ready", bus.launch_ready, 64'd1);
      chk("rst_active", active, 64'd0);
      chk("rst_crater_x", bus.crater_x, 64'd0);
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_all();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      clear_inputs();
      #2;
      do_reset();

      // Basic flight and gravity
      set_launch(100, 200, 3, -4);
      bus.launch_valid = 1'b1; cyc(); bus.launch_valid = 1'b0;
      chk("t1_active", active, 64'h1);
      tick();
      chk("t1_x_tick1", slot_x[9:0], 64'd103);
      chk("t1_y_tick1", slot_y[9:0], 64'd196);
      repeat (6) tick();
      chk("t1_x_tick7", slot_x[9:0], 64'd121);
      chk("t1_y_tick7", slot_y[9:0], 64'd173);

      // Terrain hit, crater held back, slot stays in explosion
      do_reset();
      set_launch(100, 200, 3, -4);
      bus.launch_valid = 1'b1; cyc(); bus.launch_valid = 1'b0;
      hit = 4'b0001; frame_tick = 1'b1; cyc(); hit = '0; frame_tick = 1'b0;
      chk("t2_crater_valid", bus.crater_valid, 64'd1);
      chk("t2_crater_x", bus.crater_x, 64'd100);
      chk("t2_crater_y", bus.crater_y, 64'd200);
      chk("t2_crater_r", bus.crater_r, 64'd20);
      set_launch(300, 100, 0, 0);
      bus.launch_valid = 1'b1; repeat (3) cyc(); bus.launch_valid = 1'b0;
      chk("t2_full", bus.launch_ready, 64'd0);
      repeat (20) tick();
      chk("t2_still_pending", bus.crater_valid, 64'd1);
      chk("t2_still_boom", bus.launch_ready, 64'd0);
      bus.crater_ready = 1'b1; cyc(); bus.crater_ready = 1'b0;
      chk("t2_accepted", bus.crater_valid, 64'd0);
      chk("t2_boom_until_tick", bus.launch_ready, 64'd0);
      tick();
      chk("t2_idle_after_tick", bus.launch_ready, 64'd1);
      hit = 4'b0010; frame_tick = 1'b1; cyc(); hit = '0; frame_tick = 1'b0;
      chk("t2_second_crater", bus.crater_valid, 64'd1);
      do_reset();

      // Screen exit without wrap, then velocity clamp
      set_launch(630, 100, 12, 0);
      bus.launch_valid = 1'b1; cyc(); bus.launch_valid = 1'b0;
      tick();
      chk("t3_exit_valid", bus.crater_valid, 64'd1);
      chk("t3_exit_x", bus.crater_x, 64'd630);
      chk("t3_exit_inactive", active, 64'd0);
      bus.crater_ready = 1'b1; cyc(); bus.crater_ready = 1'b0;
      set_launch(300, 100, 0, 15);
      bus.launch_valid = 1'b1; cyc(); bus.launch_valid = 1'b0;
      tick();
      chk("t3_y_unclamped", slot_y[19:10], 64'd115);
      tick();
      chk("t3_y_clamped", slot_y[19:10], 64'd127);

      // Fill all slots; fifth request waits for a freed slot
      do_reset();
      bus.launch_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         set_launch(100 + 50 * k, 100, 0, 0);
         cyc();
      end
      chk("t4_ready_low", bus.launch_ready, 64'd0);
      chk("t4_all_active", active, 64'hF);
      set_launch(400, 100, 0, 0);
      repeat (3) cyc();
      chk("t4_stalled", slot_x[29:20], 64'd200);
      hit = 4'b0100; frame_tick = 1'b1; cyc(); hit = '0; frame_tick = 1'b0;
      bus.crater_ready = 1'b1; cyc(); bus.crater_ready = 1'b0;
      repeat (15) tick();
      chk("t4_slot2_boom", active, 64'hB);
      tick();
      chk("t4_reused", active, 64'hF);
      chk("t4_slot2_x", slot_x[29:20], 64'd400);
      bus.launch_valid = 1'b0;

      // Two simultaneous craters served lowest index first
      do_reset();
      bus.launch_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         set_launch(100 + 50 * k, 300, 0, 0);
         cyc();
      end
      bus.launch_valid = 1'b0;
      bus.crater_ready = 1'b1;
      hit = 4'b1010; frame_tick = 1'b1; cyc(); hit = '0; frame_tick = 1'b0;
      chk("t5_first_valid", bus.crater_valid, 64'd1);
      chk("t5_first_x", bus.crater_x, 64'd150);
      cyc();
      chk("t5_second_valid", bus.crater_valid, 64'd1);
      chk("t5_second_x", bus.crater_x, 64'd250);
      cyc();
      chk("t5_done", bus.crater_valid, 64'd0);
      bus.crater_ready = 1'b0;

      // Sprite lookup
      do_reset();
      set_launch(50, 50, 0, 0);
      bus.launch_valid = 1'b1; cyc(); bus.launch_valid = 1'b0;
      draw_x = 10'd45; draw_y = 10'd41; #1;
      chk("t6_corner_hit", draw_hit, 64'd1);
      chk("t6_corner_addr", draw_addr, 64'd0);
      draw_x = 10'd56; draw_y = 10'd57; #1;
      chk("t6_far_hit", draw_hit, 64'd1);
      chk("t6_far_addr", draw_addr, 64'd203);
      draw_x = 10'd57; draw_y = 10'd41; #1;
      chk("t6_miss_hit", draw_hit, 64'd0);
      chk("t6_miss_addr", draw_addr, 64'd0);
      draw_x = 10'd44; #1;
      chk("t6_miss_left", draw_hit, 64'd0);

      // Randomized traffic against the model
      do_reset();
      for (int c = 0; c < 800; c++) begin
         int s;
         if (c == 400) do_reset();
         bus.launch_valid = ($urandom_range(0, 2) == 0);
         set_launch($urandom_range(5, 634), $urandom_range(5, 474),
                    int'($urandom_range(0, 30)) - 15, int'($urandom_range(0, 30)) - 15);
         wind = 2'($urandom_range(0, 3));
         frame_tick = ($urandom_range(0, 2) == 0);
         for (int i = 0; i < N; i++) hit[i] = ($urandom_range(0, 11) == 0);
         bus.crater_ready = ($urandom_range(0, 1) == 1);
         s = $urandom_range(0, N - 1);
         draw_x = 10'(m_x[s] + int'($urandom_range(0, 16)) - 8);
         draw_y = 10'(m_y[s] + int'($urandom_range(0, 22)) - 11);
         cyc();
      end
      clear_inputs();
      cyc();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
`default_nettype wire
